// File: rtl/issue_scoreboard_pkg.sv
// Shared types and helpers for the register-busy issue scoreboard.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
package issue_scoreboard_pkg;

   localparam int NUM_ARCH_REG = 32;
   localparam int REG_IDX_W    = 5;
   localparam int NUM_WB_DEF   = 2;
   localparam int CNT_W_DEF    = 6;

   typedef logic [REG_IDX_W-1:0]    reg_idx_t;
   typedef logic [NUM_ARCH_REG-1:0] reg_vec_t;

   // One issue-queue head slot as seen by the scoreboard
   typedef struct packed {
      logic     valid;
      reg_idx_t rj;
      reg_idx_t rk;
      reg_idx_t rd;
      logic     long_lat;
   } slot_t;

   // A register is hazardous when busy and not being written back this cycle
   // (wb_free is all-zero unless same-cycle bypass is enabled). r0 never is.
   function automatic logic reg_hazard(input reg_idx_t idx,
                                       input reg_vec_t busy,
                                       input reg_vec_t wb_free);
      return (idx != '0) && busy[idx] && !wb_free[idx];
   endfunction

   // Population count of a register-sized bit vector
   function automatic logic [REG_IDX_W:0] popcount(input reg_vec_t v);
      logic [REG_IDX_W:0] n;
      n = '0;
      for (int i = 0; i < NUM_ARCH_REG; i++) begin
         n = n + {{REG_IDX_W{1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/issue_sb_hazard.sv
// Per-slot hazard check: three operands against busy bits plus optional older-slot long rd.
// Latency: purely combinational.
// Backpressure: none; can_issue is the stall signal consumed by the issue stage.
module issue_sb_hazard
   import issue_scoreboard_pkg::*;
(
   input  slot_t    slot,
   input  reg_vec_t busy,
   input  reg_vec_t wb_free,
   input  logic     pair_long,
   input  reg_idx_t pair_rd,
   output logic     can_issue
);

   logic busy_hit;
   logic pair_hit;

   // RAW on rj/rk, WAW on rd, and dependence on an older long op issuing alongside
   always_comb begin
      busy_hit  = reg_hazard(slot.rj, busy, wb_free) ||
                  reg_hazard(slot.rk, busy, wb_free) ||
                  reg_hazard(slot.rd, busy, wb_free);
      pair_hit  = pair_long && (pair_rd != '0) &&
                  ((slot.rj == pair_rd) || (slot.rk == pair_rd) || (slot.rd == pair_rd));
      can_issue = !slot.valid || !(busy_hit || pair_hit);
   end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue register-busy scoreboard for long-latency uops (optional macro ISSUE_SB_BYPASS_EN).
// Latency: can_issue combinational; set/clear land in busy_vec at the next edge (clear seen same cycle with bypass).
// Backpressure: can_issue0/1 stall the issue stage; writebacks are always accepted, never stalled.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int NUM_WB = NUM_WB_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        flush,
   input  logic                        q0_valid,
   input  logic [REG_IDX_W-1:0]        q0_rj,
   input  logic [REG_IDX_W-1:0]        q0_rk,
   input  logic [REG_IDX_W-1:0]        q0_rd,
   input  logic                        q0_long,
   input  logic                        q1_valid,
   input  logic [REG_IDX_W-1:0]        q1_rj,
   input  logic [REG_IDX_W-1:0]        q1_rk,
   input  logic [REG_IDX_W-1:0]        q1_rd,
   input  logic                        q1_long,
   input  logic                        iss0_fire,
   input  logic                        iss1_fire,
   input  logic [NUM_WB-1:0]           wb_en,
   input  logic [REG_IDX_W*NUM_WB-1:0] wb_rd,
   output logic                        can_issue0,
   output logic                        can_issue1,
   output logic [NUM_ARCH_REG-1:0]     busy_vec,
   output logic [CNT_W-1:0]            outstanding,
   output logic                        idle
);

   slot_t    slot0;
   slot_t    slot1;
   reg_vec_t busy_q;
   reg_vec_t busy_d;
   reg_vec_t wb_hit;
   reg_vec_t wb_free;
   reg_vec_t set_vec;
   reg_vec_t clr_vec;
   reg_vec_t new_set;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign slot0 = {q0_valid, q0_rj, q0_rk, q0_rd, q0_long};
   assign slot1 = {q1_valid, q1_rj, q1_rk, q1_rd, q1_long};

   // Decode all writeback ports into one mask; duplicates collapse to one bit
   always_comb begin
      wb_hit = '0;
      for (int i = 0; i < NUM_WB; i++) begin
         if (wb_en[i]) begin
            wb_hit[wb_rd[i*REG_IDX_W +: REG_IDX_W]] = 1'b1;
         end
      end
      wb_hit[0] = 1'b0;
   end

`ifdef ISSUE_SB_BYPASS_EN
   // Same-cycle writeback frees the register for the hazard test (data is forwarded)
   assign wb_free = wb_hit;
`else
   // Consumers wait for the registered clear
   assign wb_free = '0;
`endif

   // Next busy state and count delta; set beats clear on the same register
   always_comb begin
      set_vec = '0;
      if (iss0_fire && q0_long) set_vec[q0_rd] = 1'b1;
      if (iss1_fire && q1_long) set_vec[q1_rd] = 1'b1;
      set_vec[0] = 1'b0;
      clr_vec = wb_hit & busy_q & ~set_vec;
      new_set = set_vec & ~busy_q;
      busy_d  = (busy_q | set_vec) & ~clr_vec;
      cnt_d   = cnt_q + CNT_W'(popcount(new_set)) - CNT_W'(popcount(clr_vec));
   end

   // Busy bits and outstanding count; flush drops every tracked op
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   issue_sb_hazard u_hz0 (
      .slot      (slot0),
      .busy      (busy_q),
      .wb_free   (wb_free),
      .pair_long (1'b0),
      .pair_rd   ('0),
      .can_issue (can_issue0)
   );

   // Slot 1 also checks slot 0's long rd from the queue fields, not the fire
   issue_sb_hazard u_hz1 (
      .slot      (slot1),
      .busy      (busy_q),
      .wb_free   (wb_free),
      .pair_long (q0_valid && q0_long),
      .pair_rd   (q0_rd),
      .can_issue (can_issue1)
   );

   assign busy_vec    = busy_q;
   assign outstanding = cnt_q;
   assign idle        = (cnt_q == '0);

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-busy scoreboard that schedules dual-issue from the issue stage.
- Tracks destination registers of in-flight long-latency uops (load, mul/div), which write back out of order through shared writeback ports.
- Tells the issue stage, per slot, whether the uop currently at the queue head may issue this cycle without a RAW or WAW hazard.
- Sits beside the issue FIFO: its grants gate the issue enables; the execute units' writeback ports release its entries.

Parameters:
- NUM_WB, 2, number of writeback ports that can release busy registers per cycle
- CNT_W, 6, width of the outstanding-op counter (must hold up to 31)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills all tracked ops
- q0_valid  in  1  slot 0 holds a real uop
- q0_rj, q0_rk, q0_rd  in  5 each  slot 0 source and destination registers
- q0_long  in  1  slot 0 uop is long-latency and writes rd
- q1_valid, q1_rj, q1_rk, q1_rd, q1_long  in  1/5/5/5/1  same fields for slot 1
- iss0_fire, iss1_fire  in  1 each  slot actually issued this cycle
- wb_en  in  NUM_WB  writeback port valid
- wb_rd  in  5*NUM_WB  writeback destination; port i occupies bits [5i+4:5i]
- can_issue0, can_issue1  out  1 each  slot may issue (combinational)
- busy_vec  out  32  registered busy bits; bit 0 is always 0
- outstanding  out  CNT_W  number of set busy bits
- idle  out  1  outstanding==0

Behaviour:
- Reset (rstn low, asynchronous): busy_vec=0, outstanding=0, idle=1.
- A register is hazardous when its busy bit is set. Register r0 is never busy and never hazardous.
- can_issue0 = !q0_valid, or none of q0_rj, q0_rk, q0_rd is hazardous. Checking rd blocks WAW.
- can_issue1 = !q1_valid, or both of the following hold:
  - none of q1_rj, q1_rk, q1_rd is hazardous;
  - no intra-pair long dependence: if q0_valid && q0_long && q0_rd!=0, then q1_rj, q1_rk and q1_rd all differ from q0_rd.
- The intra-pair check uses q0_* fields, never iss0_fire, so there is no combinational loop. Short-latency intra-pair RAW is not this block's concern.
- Set rule: at a clock edge with issN_fire && qN_long && qN_rd!=0, busy[qN_rd] <= 1.
- Clear rule: at a clock edge with wb_en[i] && wb_rd[i]!=0 && busy[wb_rd[i]], busy[wb_rd[i]] <= 0.
  - Writeback to a non-busy register is ignored.
  - Two ports naming the same register clear it once.
- Set and clear of the same register in one cycle: set wins; the bit stays busy and belongs to the new producer.
- Both slots setting the same rd cannot occur: WAW stall prevents it. If it occurs anyway, the bit is set once.
- outstanding is updated incrementally each cycle: + number of newly set bits, − number of newly cleared bits.
  - Invariant: outstanding == popcount(busy_vec).
  - A set-wins collision on an already-busy register leaves the count unchanged.
- flush (synchronous, highest priority below reset): busy_vec<=0, outstanding<=0. Sets and clears in the same cycle are discarded. Later writebacks from killed ops hit non-busy registers and are ignored.
- Latency: a set is visible on can_issue in the next cycle; a clear is visible in the next cycle unless ISSUE_SB_BYPASS_EN is defined.

Optional Feature:
- Macro ISSUE_SB_BYPASS_EN.
- Defined: the hazard test also treats a register as free when any wb_en[i] with matching wb_rd[i] is asserted in the same cycle. This requires writeback data forwarding to the issue operands. Set-wins still applies to the stored bit.
- Undefined: the hazard test uses only the registered busy_vec. A consumer issues at the earliest one cycle after writeback.

Decomposition:
- Shared package/header holds:
  - NUM_ARCH_REG=32 and REG_IDX_W=5;
  - WB port count default;
  - the hazard-check function (reg index, busy vector, wb vectors → hazard).
- Natural sub-module: issue_sb_hazard. It is combinational, per slot, compares three operands against busy/bypass, and is instantiated twice.

Test Plan:
- Reset then q0 rj=5, rk=6, rd=7, valid, iss0_fire with q0_long=1 → next cycle busy_vec[7]=1, outstanding=1. Then q0 rj=7 → can_issue0=0.
- wb_en[0]=1, wb_rd=7 while q0 reads r7 → same cycle can_issue0=1 with ISSUE_SB_BYPASS_EN, 0 without. Next cycle busy_vec=0, idle=1.
- q0 long rd=3, q1 rj=3 → can_issue1=0, can_issue0=1. Same with q0_long=0 → can_issue1=1.
- r3 busy; iss0_fire long rd=3 and wb_en[1] wb_rd=3 in the same cycle → busy_vec[3] stays 1, outstanding unchanged.
- Long ops to r1, r2, r9; flush together with a new long fire to r4 → next cycle busy_vec=0, outstanding=0. A later wb to r2 → no change.
- Long fire rd=0, and wb to r0 → busy_vec stays 0. Both wb ports target busy r12 → outstanding decrements by exactly 1.
